// File: rtl/datamemory_sized.sv
// datamemory_sized
//
// Byte-addressable data memory for the MIPS datapath. It handles byte,
// halfword and word loads and stores, with optional sign extension on loads.
// The access latency is configurable and uses a req/busy/done handshake.
// Misaligned and illegal accesses complete with err=1 and do not write.
//
// Parameters
//   ADDR_W       byte-address width; depth = 2**(ADDR_W-2) 32-bit words
//   WAIT_STATES  extra cycles per access, 0..15
//
// Optional feature
//   DMEM_CLEAR_EN  When this macro is defined, a zeroing sweep runs over the
//                  whole array after every reset. When it is not defined, the
//                  array powers up undefined.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req        access request
//   we         1 = store, 0 = load
//   size       00 byte, 01 half, 10 word, 11 illegal
//   sign_ext   loads only: sign-extend byte/half results
//   address    byte address
//   data_in    right-justified store data
//   data_out   right-justified, extended load result
//   busy       access or clear sweep in progress
//   done       one-cycle completion pulse
//   err        qualifies done: access was misaligned or illegal
//   dbg_state  current FSM state, for observation only
//
// Handshake: a request is taken on any rising edge where req=1 and busy=0.
// The design samples we/size/sign_ext/address/data_in only on that edge. A
// req seen while busy=1 is dropped. Each accepted request produces exactly
// one done pulse, 1+WAIT_STATES edges later. data_out and err are valid with
// done and keep their values until the next done.

module datamemory_sized #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int         DEPTH = 1 << (ADDR_W - 2);
    localparam int         IDX_W = ADDR_W - 2;
    localparam logic [3:0] WS    = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2
`ifdef DMEM_CLEAR_EN
        ,ST_CLEAR = 2'd3
`endif
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [31:0]         dout_q;

    // Captured request fields
    logic                we_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

`ifdef DMEM_CLEAR_EN
    logic [IDX_W-1:0]    clr_q;
    logic                clr_pending_q;
`endif

    logic [31:0]         mem [DEPTH];

    logic                accept_d;
    logic                complete_d;
    logic                misaligned_d;
    logic [31:0]         rd_word_d;
    logic [31:0]         lanes_d;
    logic [31:0]         load_d;
    logic                wr_en_d;
    logic [IDX_W-1:0]    wr_idx_d;
    logic [3:0]          wr_be_d;
    logic [31:0]         wr_data_d;

    // Request acceptance and completion decode
    always_comb begin
        accept_d   = req && (state_q == ST_IDLE || state_q == ST_RESP);
`ifdef DMEM_CLEAR_EN
        // A pending sweep takes priority over any request.
        accept_d   = accept_d && !clr_pending_q;
`endif
        complete_d = (state_q == ST_WAIT) && (cnt_q == WS);
    end

    // Datapath: alignment check, load lane select and extension, store lanes
    always_comb begin
        misaligned_d = (size_q == 2'b11) ||
                       (size_q == 2'b01 && addr_q[0]) ||
                       (size_q == 2'b10 && addr_q[1:0] != 2'b00);

        rd_word_d = mem[addr_q[ADDR_W-1:2]];
        // Move the addressed lane down to bit 0.
        lanes_d   = rd_word_d >> {addr_q[1:0], 3'b000};

        case (size_q)
            2'b00:   load_d = {{24{sext_q & lanes_d[7]}},  lanes_d[7:0]};
            2'b01:   load_d = {{16{sext_q & lanes_d[15]}}, lanes_d[15:0]};
            2'b10:   load_d = rd_word_d;
            default: load_d = 32'h0;
        endcase
        if (misaligned_d || we_q) begin
            load_d = 32'h0;
        end

        // Replicate the store data across the word so that the byte enables
        // alone select the destination lanes.
        case (size_q)
            2'b00: begin
                wr_be_d   = 4'b0001 << addr_q[1:0];
                wr_data_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be_d   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data_d = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be_d   = 4'b1111;
                wr_data_d = wdata_q;
            end
        endcase
        wr_idx_d = addr_q[ADDR_W-1:2];
        // Gating with rst_n drops a store whose commit edge coincides with reset.
        wr_en_d  = rst_n && complete_d && we_q && !misaligned_d;

`ifdef DMEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            wr_en_d   = rst_n;
            wr_idx_d  = clr_q;
            wr_be_d   = 4'b1111;
            wr_data_d = 32'h0;
        end
`endif
    end

    // Storage array; never reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_d && wr_be_d[b]) begin
                mem[wr_idx_d][8*b +: 8] <= wr_data_d[8*b +: 8];
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= 32'h0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
`ifdef DMEM_CLEAR_EN
            clr_q         <= '0;
            clr_pending_q <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;

            if (accept_d) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sign_ext;
                addr_q  <= address;
                wdata_q <= data_in;
                cnt_q   <= 4'd0;
                busy_q  <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
`ifdef DMEM_CLEAR_EN
                    if (clr_pending_q) begin
                        clr_pending_q <= 1'b0;
                        clr_q         <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_CLEAR;
                    end else
`endif
                    if (accept_d) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (complete_d) begin
                        state_q  <= ST_RESP;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= misaligned_d;
                        dout_q   <= load_d;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_RESP: begin
                    // busy is already low here, so a new request can be
                    // taken on the edge that ends the done cycle.
                    state_q <= accept_d ? ST_WAIT : ST_IDLE;
                end
`ifdef DMEM_CLEAR_EN
                ST_CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == IDX_W'(DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out  = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_datamemory_sized.sv
// Self-checking bench for datamemory_sized (ADDR_W=8, WAIT_STATES=2).
// The reference model is a flat byte array addressed the way software sees
// memory. Multi-byte values are assembled arithmetically from that array.

module tb_datamemory_sized;

    localparam int AW    = 8;
    localparam int WS    = 2;
    localparam int DEPTH = 1 << (AW - 2);
    localparam int NBYTE = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    dbg_state;

    datamemory_sized #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          tests  = 0;
    int          failed = 0;
    logic [7:0]  byte_mem [NBYTE];
    logic [31:0] exp_q [$];
    logic        exp_err_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the access viewed as 1, 2 or 4 consecutive bytes
    function automatic void model_access(input logic w, input logic [1:0] sz, input logic sx,
                                         input logic [AW-1:0] a, input logic [31:0] d,
                                         output logic [31:0] r, output logic e);
        int     n;
        longint v;
        n = 1 << sz;
        r = 32'h0;
        e = (sz == 2'b11) || ((int'(a) % n) != 0);
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) byte_mem[int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(byte_mem[int'(a) + i]) << (8 * i);
            if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
            r = v[31:0];
        end
    endfunction

    // Driver: one complete access, checked against the model
    task automatic do_acc(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        int          lat;
        model_access(w, sz, sx, a, d, r, e);
        exp_q.push_back(r);
        exp_err_q.push_back(e);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; address = a; data_in = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        // Scramble the inputs; the captured request must not change.
        we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        address = AW'($urandom); data_in = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err_q.pop_front()));
        r = exp_q.pop_front();
        if (!w || e) check({tag, "_data"}, data_out, r);
    endtask

    // After reset release: with the sweep enabled, time it and zero the model
    task automatic post_reset();
`ifdef DMEM_CLEAR_EN
        int n;
        n = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) n++;
        end
        check("clear_busy_cycles", 32'(n), 32'(DEPTH));
        for (int i = 0; i < NBYTE; i++) byte_mem[i] = 8'h00;
`endif
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        address = '0; data_in = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();

`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) do_acc("clear_rd", 1'b0, 2'b10, 1'b0, AW'(4 * i), 32'h0);
`endif

        // Give every word a defined value
        for (int i = 0; i < DEPTH; i++) do_acc("init", 1'b1, 2'b10, 1'b0, AW'(4 * i), $urandom);

        // Word round trip
        do_acc("word_st", 1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678);
        do_acc("word_ld", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        check("word_ld_const", data_out, 32'h12345678);

        // Byte lanes
        do_acc("b0", 1'b1, 2'b00, 1'b0, 8'h20, 32'hFFFFFF11);
        do_acc("b1", 1'b1, 2'b00, 1'b0, 8'h21, 32'h00000022);
        do_acc("b2", 1'b1, 2'b00, 1'b0, 8'h22, 32'hABCDEF33);
        do_acc("b3", 1'b1, 2'b00, 1'b0, 8'h23, 32'h00000080);
        do_acc("bw_ld", 1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
        check("bw_const", data_out, 32'h80332211);
        do_acc("b3_sx", 1'b0, 2'b00, 1'b1, 8'h23, 32'h0);
        check("b3_sx_const", data_out, 32'hFFFFFF80);
        do_acc("b3_zx", 1'b0, 2'b00, 1'b0, 8'h23, 32'h0);
        check("b3_zx_const", data_out, 32'h00000080);

        // Halfword
        do_acc("h_base", 1'b1, 2'b10, 1'b0, 8'h40, 32'hAAAAAAAA);
        do_acc("h_st", 1'b1, 2'b01, 1'b0, 8'h42, 32'h12348001);
        do_acc("h_word", 1'b0, 2'b10, 1'b0, 8'h40, 32'h0);
        check("h_word_const", data_out, 32'h8001AAAA);
        do_acc("h_sx", 1'b0, 2'b01, 1'b1, 8'h42, 32'h0);
        check("h_sx_const", data_out, 32'hFFFF8001);

        // Errors: no write, err=1, data_out=0
        do_acc("e_word", 1'b1, 2'b10, 1'b0, 8'h41, 32'h55555555);
        do_acc("e_half", 1'b1, 2'b01, 1'b0, 8'h43, 32'h55555555);
        do_acc("e_sz3", 1'b1, 2'b11, 1'b0, 8'h40, 32'h55555555);
        do_acc("e_ld3", 1'b0, 2'b11, 1'b1, 8'h44, 32'h0);
        do_acc("e_chk", 1'b0, 2'b10, 1'b0, 8'h40, 32'h0);
        check("e_chk_const", data_out, 32'h8001AAAA);

        // A req while busy is dropped: exactly one done for the load
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; address = 8'h10;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; address = 8'h60; data_in = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        check("hs_dones", 32'(dones), 32'd1);
        check("hs_data", data_out, 32'h12345678);
        do_acc("hs_unwritten", 1'b0, 2'b10, 1'b0, 8'h60, 32'h0);

        // Reset during the wait of a store: outputs clear, store discarded
        do_acc("pre_rst_ld", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; address = 8'h50; data_in = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_data", data_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();
        do_acc("mid_rst_word", 1'b0, 2'b10, 1'b0, 8'h50, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            do_acc("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   AW'($urandom_range(0, NBYTE - 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
